// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer: registered head (out_data) plus one skid slot,
// with a registered in_ready so upstream stalls never see a combinational ready chain.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam int unsigned CW = 2;

  // State bits are {out_valid, skid_valid}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_state[1] & out_ready;

  // Next-state and data-path selection; flush drops everything but leaves data regs untouched.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_data_nxt  = r_out_data;
    w_skid_data_nxt = r_skid_data;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = S_ONE;
            w_out_data_nxt = in_data;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_out_data_nxt = in_data;
          end else if (w_in_fire) begin
            w_state_nxt     = S_FULL;
            w_skid_data_nxt = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt    = S_ONE;
            w_out_data_nxt = r_skid_data;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    w_count_nxt = CW'(0);
    case (w_state_nxt)
      S_ONE:   w_count_nxt = CW'(1);
      S_FULL:  w_count_nxt = CW'(2);
      default: w_count_nxt = CW'(0);
    endcase
  end

  // in_ready stays low for one cycle after reset, then mirrors "skid slot free".
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_count     <= CW'(0);
      r_out_data  <= RESET_VAL;
      r_skid_data <= RESET_VAL;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_count     <= w_count_nxt;
      r_out_data  <= w_out_data_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  assign out_valid = r_state[1];
  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: WIDTH=8 and WIDTH=64 instances against a 2-deep FIFO model,
// directed reset/stream/backpressure/flush steps followed by a random soak.
module tb_pipe_skid_reg;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  logic flush;

  logic        iv0, or0, ir0, ov0;
  logic [7:0]  id0, od0;
  logic [1:0]  c0;
  logic        iv1, or1, ir1, ov1;
  logic [63:0] id1, od1;
  logic [1:0]  c1;

  pipe_skid_reg #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .count(c0)
  );

  pipe_skid_reg #(.WIDTH(64)) dut64 (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(c1)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference: a queue of at most two entries, plus the last head value shown.
  int          m_cnt  [2];
  logic [63:0] m_ent  [2][2];
  logic [63:0] m_data [2];
  logic        m_rdy  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_lane(input int l, input logic iv, input logic ordy, input logic [63:0] d);
    logic inf, outf;
    inf  = iv & m_rdy[l];
    outf = (m_cnt[l] > 0) & ordy;
    if (RST) begin
      m_cnt[l]  = 0;
      m_data[l] = 64'h0;
      m_rdy[l]  = 1'b0;
    end else if (flush) begin
      m_cnt[l] = 0;
      m_rdy[l] = 1'b1;
    end else begin
      if (outf) begin
        m_ent[l][0] = m_ent[l][1];
        m_cnt[l]--;
      end
      if (inf) begin
        m_ent[l][m_cnt[l]] = d;
        m_cnt[l]++;
      end
      m_rdy[l] = (m_cnt[l] < 2);
      if (m_cnt[l] > 0) m_data[l] = m_ent[l][0];
    end
  endtask

  // Advance the model with the current inputs, clock once, compare every output of both lanes.
  task automatic step();
    model_lane(0, iv0, or0, {56'h0, id0});
    model_lane(1, iv1, or1, id1);
    @(posedge CLK);
    #1;
    chk("w8_out_valid", 64'(ov0), 64'(m_cnt[0] > 0));
    chk("w8_in_ready",  64'(ir0), 64'(m_rdy[0]));
    chk("w8_count",     64'(c0),  64'(m_cnt[0]));
    chk("w8_out_data",  64'(od0), m_data[0]);
    chk("w64_out_valid", 64'(ov1), 64'(m_cnt[1] > 0));
    chk("w64_in_ready",  64'(ir1), 64'(m_rdy[1]));
    chk("w64_count",     64'(c1),  64'(m_cnt[1]));
    chk("w64_out_data",  od1,      m_data[1]);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_cnt[l] = 0; m_data[l] = 64'h0; m_rdy[l] = 1'b0;
      m_ent[l][0] = 64'h0; m_ent[l][1] = 64'h0;
    end
    RST = 1'b1; flush = 1'b0;
    iv0 = 1'b1; id0 = 8'hFF; or0 = 1'b0;
    iv1 = 1'b1; id1 = 64'hDEAD_BEEF_0123_4567; or1 = 1'b0;

    // Reset held two cycles with in_valid high
    step();
    step();
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_count",     64'(c0),  64'd0);
    chk("rst_out_data",  64'(od0), 64'd0);
    chk("rst_in_ready",  64'(ir0), 64'd0);
    chk("rst_out_data64", od1, 64'd0);

    RST = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
    step();
    chk("ready_after_rst", 64'(ir0), 64'd1);

    // Streaming with out_ready held high
    or0 = 1'b1; iv0 = 1'b1;
    id0 = 8'h11; step(); chk("stream_11", 64'(od0), 64'h11); chk("stream_cnt1", 64'(c0), 64'd1);
    id0 = 8'h22; step(); chk("stream_22", 64'(od0), 64'h22);
    id0 = 8'h33; step(); chk("stream_33", 64'(od0), 64'h33); chk("stream_rdy", 64'(ir0), 64'd1);
    iv0 = 1'b0; step(); chk("stream_drain", 64'(c0), 64'd0);

    // Backpressure fills the skid slot
    or0 = 1'b0; iv0 = 1'b1;
    id0 = 8'hA5; step(); chk("bp_first", 64'(od0), 64'hA5);
    id0 = 8'h5A; step(); chk("bp_full_cnt", 64'(c0), 64'd2); chk("bp_full_rdy", 64'(ir0), 64'd0);
    iv0 = 1'b0; step(); chk("bp_hold", 64'(od0), 64'hA5);

    // Drain in order
    or0 = 1'b1;
    step(); chk("drain_5a", 64'(od0), 64'h5A); chk("drain_cnt1", 64'(c0), 64'd1);
    step(); chk("drain_cnt0", 64'(c0), 64'd0); chk("drain_hold", 64'(od0), 64'h5A);

    // Refill, then flush while FULL with a beat offered
    or0 = 1'b0; iv0 = 1'b1;
    id0 = 8'hA5; step();
    id0 = 8'h5A; step();
    flush = 1'b1; id0 = 8'h77;
    step();
    chk("flush_valid", 64'(ov0), 64'd0); chk("flush_cnt", 64'(c0), 64'd0); chk("flush_rdy", 64'(ir0), 64'd1);
    flush = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    step(); chk("flush_no_77", 64'(ov0), 64'd0);

    // Reset while FULL
    or0 = 1'b0; iv0 = 1'b1;
    id0 = 8'hC3; step();
    id0 = 8'h3C; step(); chk("pre_rst_full", 64'(c0), 64'd2);
    RST = 1'b1; step();
    chk("rstfull_valid", 64'(ov0), 64'd0); chk("rstfull_data", 64'(od0), 64'd0); chk("rstfull_rdy", 64'(ir0), 64'd0);
    RST = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    step(); chk("rstfull_no_emit", 64'(ov0), 64'd0);

    // Random soak on both widths, occasional flush
    for (int i = 0; i < 10000; i++) begin
      iv0 = 1'($urandom_range(0, 1)); or0 = 1'($urandom_range(0, 1)); id0 = 8'($urandom);
      iv1 = 1'($urandom_range(0, 1)); or1 = 1'($urandom_range(0, 1)); id1 = {$urandom, $urandom};
      flush = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
